// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the five-stage core's pipeline control.
//   TUSE_NONE  : Tuse code meaning "this source register is not read"
//   REG_ZERO   : architectural $0, never a real dependency
//   MULT_CYC_DEF / DIV_CYC_DEF : default MDU occupancy in cycles
//   tnew_t     : 2-bit Tuse/Tnew cycle-distance type
//   src_hazard : RAW check of one D-stage source against the E and M writers
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [1:0] TUSE_NONE    = 2'd3;
    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         MULT_CYC_DEF = 5;
    localparam int         DIV_CYC_DEF  = 10;

    typedef logic [1:0] tnew_t;

    // A source stalls when a younger-than-needed result is still in flight.
    // Tnew == 0 means the value is forwardable, and Tuse >= Tnew never stalls,
    // so TUSE_NONE (the largest code) can never trigger on its own; the
    // explicit test just keeps the intent obvious.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input tnew_t      tuse,
        input logic [4:0] e_wreg,
        input tnew_t      e_tnew,
        input logic [4:0] m_wreg,
        input tnew_t      m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (e_wreg == src) && (tuse < e_tnew);
        hit_m = (m_wreg == src) && (tuse < m_tnew);
        return (src != REG_ZERO) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/md_countdown.sv
// -----------------------------------------------------------------------------
// md_countdown
// Occupancy counter for the multiply/divide unit.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   start      : E stage launches mult/multu/div/divu this cycle
//   div        : qualifies start; 1 = divide, 0 = multiply
//   busy       : counter nonzero (MDU occupied)
//   done       : registered one-cycle pulse in the cycle after the count
//                reaches zero by decrementing
// -----------------------------------------------------------------------------
module md_countdown
    import core_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            // A reload while busy restarts the count and suppresses the
            // pending completion pulse.
            cnt_d = div ? LOAD_DIV : LOAD_MULT;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_ONE;
            done_d = (cnt_q == CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            done  <= done_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller: decides each cycle whether F->D and the PC
// hold (stall) and whether a bubble enters D->E (flush_E).
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   D_rs, D_rt           : D-stage source registers
//   D_Tuse_rs, D_Tuse_rt : cycles until D needs each source (3 = unused)
//   D_is_md              : D instruction uses the MDU
//   E_wreg, M_wreg       : destination registers in E and M (0 = none)
//   E_Tnew, M_Tnew       : cycles until E/M results are available
//   E_md_start, E_md_div : E launches an MDU op; div selects divide
//   cnt_clr              : synchronous clear of stall_cnt
//   stall, flush_E       : hold request and bubble insert (same signal)
//   md_busy, md_done     : MDU occupancy and completion pulse
//   stall_cnt            : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  tnew_t       D_Tuse_rs,
    input  tnew_t       D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wreg,
    input  logic [4:0]  M_wreg,
    input  tnew_t       E_Tnew,
    input  tnew_t       M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        cnt_clr,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    logic        haz_rs;
    logic        haz_rt;
    logic        haz_md;
    logic [31:0] stall_cnt_q;

    md_countdown #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_countdown (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .div   (E_md_div),
        .busy  (md_busy),
        .done  (md_done)
    );

    assign haz_rs = src_hazard(D_rs, D_Tuse_rs, E_wreg, E_Tnew, M_wreg, M_Tnew);
    assign haz_rt = src_hazard(D_rt, D_Tuse_rt, E_wreg, E_Tnew, M_wreg, M_Tnew);

    // An MDU op launching in E this very cycle already occupies the unit for
    // the D instruction behind it, even though md_busy rises one cycle later.
    assign haz_md = D_is_md && (md_busy || E_md_start);

    // Reset is folded in so nothing is held or flushed while the core resets.
    assign stall   = reset && (haz_rs || haz_rt || haz_md);
    assign flush_E = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_wreg, M_wreg;
    logic [1:0]  E_Tnew, M_Tnew;
    logic        E_md_start, E_md_div, cnt_clr;
    logic        stall, flush_E, md_busy, md_done;
    logic [31:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_wreg     (E_wreg),
        .M_wreg     (M_wreg),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .cnt_clr    (cnt_clr),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .stall_cnt  (stall_cnt)
    );

    // ---------------- reference model ----------------
    // MDU occupancy is tracked as "last busy cycle index" on a cycle counter.
    longint      m_cyc;
    longint      m_end;
    logic [31:0] m_cnt;

    function automatic bit ref_src_haz(int src, int tuse, int ew, int et, int mw, int mt);
        if (src == 0 || tuse == 3) return 0;
        return (ew == src && tuse < et) || (mw == src && tuse < mt);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_is_md = 1'b0; E_wreg = 5'd0; M_wreg = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic drive_rs_hazard();
        drive_idle();
        D_rs = 5'd12; D_Tuse_rs = 2'd0; E_wreg = 5'd12; E_Tnew = 2'd1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        drive_rs_hazard();
        D_is_md = 1'b1; E_md_start = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        n_vec++; if (flush_E !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%0b exp=0", flush_E); end
        n_vec++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_err++; $display("FAIL reset_md got=%0b%0b exp=00", md_busy, md_done); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0h exp=0", stall_cnt); end
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_noload got=%0b exp=0", md_busy); end
    endtask

    task automatic test_raw();
        @(negedge clk); drive_idle();
        D_rs = 5'd8; D_Tuse_rs = 2'd0; E_wreg = 5'd8; E_Tnew = 2'd2; #1;
        n_vec++; if ({stall, flush_E} !== 2'b11) begin n_err++; $display("FAIL raw_e got=%b exp=11", {stall, flush_E}); end
        @(negedge clk); E_wreg = 5'd0; E_Tnew = 2'd0; M_wreg = 5'd8; M_Tnew = 2'd1; #1;
        n_vec++; if ({stall, flush_E} !== 2'b11) begin n_err++; $display("FAIL raw_m got=%b exp=11", {stall, flush_E}); end
        @(negedge clk); M_Tnew = 2'd0; #1;
        n_vec++; if ({stall, flush_E} !== 2'b00) begin n_err++; $display("FAIL raw_fwd got=%b exp=00", {stall, flush_E}); end
        @(negedge clk); drive_idle();
        D_rt = 5'd5; D_Tuse_rt = 2'd1; E_wreg = 5'd5; E_Tnew = 2'd1; #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_rt_eq got=%0b exp=0", stall); end
        @(negedge clk); E_Tnew = 2'd2; #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_rt got=%0b exp=1", stall); end
    endtask

    task automatic test_zero_nouse();
        @(negedge clk); drive_idle();
        D_rs = 5'd0; D_Tuse_rs = 2'd0; E_wreg = 5'd0; E_Tnew = 2'd2; #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_reg got=%0b exp=0", stall); end
        @(negedge clk); drive_idle();
        D_rt = 5'd9; D_Tuse_rt = 2'd3; E_wreg = 5'd9; E_Tnew = 2'd3; #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL no_use got=%0b exp=0", stall); end
    endtask

    task automatic test_mult_mfhi();
        @(negedge clk); drive_idle();
        E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1; #1;
        n_vec++; if (stall !== 1'b1 || md_busy !== 1'b0) begin n_err++; $display("FAIL mult_t0 got=%0b%0b exp=10", stall, md_busy); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); E_md_start = 1'b0; #1;
            n_vec++;
            if (stall !== (k <= 5) || md_busy !== (k <= 5) || md_done !== (k == 6)) begin
                n_err++;
                $display("FAIL mult_t%0d stall/busy/done got=%0b%0b%0b exp=%0b%0b%0b",
                         k, stall, md_busy, md_done, k <= 5, k <= 5, k == 6);
            end
        end
    endtask

    task automatic test_div();
        int busy_n;
        int done_n;
        int done_at;
        busy_n = 0; done_n = 0; done_at = -1;
        @(negedge clk); drive_idle();
        E_md_start = 1'b1; E_md_div = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk); E_md_start = 1'b0; #1;
            if (md_busy === 1'b1) busy_n++;
            if (md_done === 1'b1) begin done_n++; done_at = k; end
        end
        n_vec++; if (busy_n != 10) begin n_err++; $display("FAIL div_busy cycles=%0d exp=10", busy_n); end
        n_vec++; if (done_n != 1 || done_at != 11) begin n_err++; $display("FAIL div_done pulses=%0d at=%0d exp=1 at 11", done_n, done_at); end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk); drive_idle();
        E_md_start = 1'b1; E_md_div = 1'b1;
        @(negedge clk); E_md_start = 1'b0;
        repeat (4) @(negedge clk);
        D_is_md = 1'b1; #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL middiv_pre got=%0b exp=1", stall); end
        #1 reset = 1'b0; #1;
        n_vec++; if (md_busy !== 1'b0 || stall !== 1'b0 || md_done !== 1'b0) begin
            n_err++; $display("FAIL middiv_rst busy/stall/done got=%0b%0b%0b exp=000", md_busy, stall, md_done);
        end
        @(negedge clk); reset = 1'b1; drive_idle();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            n_vec++; if (md_done !== 1'b0 || md_busy !== 1'b0) begin
                n_err++; $display("FAIL middiv_after%0d busy/done got=%0b%0b exp=00", k, md_busy, md_done);
            end
        end
    endtask

    task automatic test_perf();
        @(negedge clk); drive_idle(); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_clr got=%0h exp=0", stall_cnt); end
        @(negedge clk); drive_rs_hazard();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); drive_idle(); #1;
        n_vec++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL perf_three got=%0h exp=3", stall_cnt); end
        @(negedge clk); drive_rs_hazard(); cnt_clr = 1'b1;
        @(negedge clk); drive_idle(); #1;
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_clr_stall got=%0h exp=0", stall_cnt); end
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        drive_rs_hazard();
        @(negedge clk); #1;
        n_vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL perf_sat1 got=%0h exp=ffffffff", stall_cnt); end
        @(negedge clk); drive_idle(); #1;
        n_vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL perf_sat2 got=%0h exp=ffffffff", stall_cnt); end
    endtask

    task automatic test_random();
        bit          e_stall;
        bit          e_busy;
        bit          e_done;
        @(negedge clk); drive_idle(); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m_cyc = 0; m_end = -100; m_cnt = 32'd0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
            E_wreg = 5'($urandom_range(0, 3)); M_wreg = 5'($urandom_range(0, 3));
            E_Tnew = 2'($urandom_range(0, 3)); M_Tnew = 2'($urandom_range(0, 3));
            D_is_md = ($urandom_range(0, 3) == 0);
            E_md_start = ($urandom_range(0, 9) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 19) == 0);
            #1;
            e_busy  = (m_cyc <= m_end);
            e_done  = (m_cyc == m_end + 1);
            e_stall = ref_src_haz(D_rs, D_Tuse_rs, E_wreg, E_Tnew, M_wreg, M_Tnew) ||
                      ref_src_haz(D_rt, D_Tuse_rt, E_wreg, E_Tnew, M_wreg, M_Tnew) ||
                      (D_is_md && (e_busy || E_md_start));
            n_vec++;
            if (stall !== e_stall || flush_E !== e_stall || md_busy !== e_busy ||
                md_done !== e_done || stall_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL rand%0d stall/flush/busy/done/cnt got=%0b%0b%0b%0b/%0h exp=%0b%0b%0b%0b/%0h",
                         n, stall, flush_E, md_busy, md_done, stall_cnt,
                         e_stall, e_stall, e_busy, e_done, m_cnt);
            end
            if (cnt_clr) m_cnt = 32'd0;
            else if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (E_md_start) m_end = m_cyc + (E_md_div ? 10 : 5);
            m_cyc++;
        end
        @(negedge clk); drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_raw();
        test_zero_nouse();
        test_mult_mfhi();
        test_div();
        test_reset_mid_div();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
